mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
- Single-port memory controller/arbiter for the core.
- Shares one byte-wide RAM port between instruction fetch (IF) and the load/store stage (MEM).
- Serialises each 1/2/4-byte access into byte transfers and assembles read data little-endian.
- Raises a stall request so the pipeline, including the EX stage, holds while an access is outstanding.

Parameters:
- RAM_AW, 17, RAM address width; the low RAM_AW bits of each byte address drive ram_addr_o.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_req_i  in  1  IF read request, held until if_done_o.
- if_addr_i  in  32  IF byte address; always a 4-byte read.
- if_done_o  out  1  one-cycle completion pulse for IF.
- if_data_o  out  32  instruction word, valid while if_done_o=1.
- mem_req_i  in  1  MEM request, held until mem_done_o.
- mem_we_i  in  1  1=write, 0=read.
- mem_len_i  in  2  00=byte, 01=half, 10=word; 11 is treated as word.
- mem_addr_i  in  32  MEM byte address.
- mem_wdata_i  in  32  write data; byte i is bits [8i+7:8i].
- mem_done_o  out  1  one-cycle completion pulse for MEM.
- mem_rdata_o  out  32  read data, zero-extended, valid while mem_done_o=1.
- ram_addr_o  out  RAM_AW  RAM byte address.
- ram_wr_o  out  1  RAM write strobe.
- ram_dout_o  out  8  RAM write byte.
- ram_din_i  in  8  RAM read byte; one-cycle read latency.
- stall_req_o  out  1  pipeline stall request.

Behaviour:
- Reset: clk is the single clock; rst is asynchronous and active-low. While rst=0, all registered outputs are 0, the FSM is IDLE and the byte counter is 0. Reset asserted mid-transfer aborts it immediately: ram_wr_o drops with no clock, and no done pulse is issued.
- FSM states: IDLE, XFER, DONE.
- IDLE: at the sampling edge E0, grant MEM if mem_req_i=1, else IF if if_req_i=1. Latch address, length n (1/2/4), direction, write data and owner; go to XFER with cnt=0.
- XFER: after edge E_i (i=0..n-1), ram_addr_o=(addr+i)[RAM_AW-1:0], computed in 32 bits then truncated, so it wraps at 2^RAM_AW.
  - Write: ram_wr_o=1 and ram_dout_o=wdata byte i.
  - Read: ram_wr_o=0. The byte requested after E_i is present on ram_din_i after E_{i+1} and is captured at E_{i+2} into bits [8i+7:8i]; bits above 8n-1 are 0.
- Latency:
  - Write of n bytes: done pulse after edge E_n.
  - Read of n bytes: done pulse after edge E_{n+1}. A word fetch takes 5 edges from sampling to done.
- DONE: exactly one cycle. The owner's done_o=1 with its data valid; ram_wr_o=0; new requests are not sampled. Next edge returns to IDLE.
- Throughput: at least one IDLE cycle between transactions.
- Non-preemptive: a transfer in XFER always completes, even if a higher-priority request arrives.
- Requests dropped mid-transfer (a protocol violation) do not abort the transfer. The done pulse is still issued.
- Simultaneous IF and MEM requests in IDLE: MEM wins (older instruction). IF stays pending and is served next.
- stall_req_o is combinational: (if_req_i & ~if_done_o) | (mem_req_i & ~mem_done_o).
- Data outputs: if_data_o and mem_rdata_o hold their last value after done until the next completion of the same owner.

Optional Feature:
- Macro: MEM_CTRL_FAIR_EN.
- Defined: add a 1-bit last-grant register, reset to IF. When both requests are present in IDLE and the last grant was MEM, grant IF; otherwise grant MEM. Single requests are granted as normal.
- Not defined: fixed MEM-over-IF priority; the register is absent.

Test Plan:
- IF word read:
  - Stimulus: if_addr=0x10, RAM[0x10..0x13]=78 56 34 12.
  - Response: ram_addr steps 0x10..0x13 on consecutive cycles; if_done pulses 5 edges after sampling with if_data=0x12345678; stall_req_o=1 until then.
- MEM byte write:
  - Stimulus: addr=0x1003, wdata=0xAABBCCDD, len=00.
  - Response: one cycle with ram_wr=1, ram_addr=0x1003, ram_dout=0xDD; mem_done pulses on the next cycle.
- MEM half read:
  - Stimulus: addr=0x20, RAM=0xEF 0xBE.
  - Response: mem_rdata=0x0000BEEF; done 3 edges after sampling.
- Simultaneous requests, macro off:
  - Stimulus: IF and MEM both requested.
  - Response: MEM is served first. IF starts after DONE plus one IDLE cycle. A second MEM request arriving during the IF transfer waits.
- Reset mid-write:
  - Stimulus: rst=0 during the 2nd byte of a word write.
  - Response: ram_wr_o=0 immediately; no done pulse; IDLE after release.
- Fairness, MEM_CTRL_FAIR_EN defined:
  - Stimulus: both requests held continuously.
  - Response: grants alternate MEM, IF, MEM, IF.

Source files
------------

// File: rtl/mem_ctrl.sv
// Purpose: single-port byte-wide RAM arbiter shared by IF and MEM; serialises 1/2/4-byte accesses, little-endian.
// Latency: write n bytes -> done after n edges past sampling; read n bytes -> done after n+1 edges.
// Backpressure: requesters hold *_req_i until their done pulse, and stall_req_o holds the pipeline meanwhile.
// Optional macro MEM_CTRL_FAIR_EN: alternate grants between IF and MEM when both request in IDLE.
module mem_ctrl #(
    parameter int RAM_AW = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    output logic              if_done_o,
    output logic [31:0]       if_data_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_len_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              mem_done_o,
    output logic [31:0]       mem_rdata_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic              ram_wr_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i,
    output logic              stall_req_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        n_q, n_d;
    logic [RAM_AW-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              own_mem_q, own_mem_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic              ram_wr_q, ram_wr_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;

    logic              grant_mem, grant_if;
    logic [2:0]        nxt;
    logic [1:0]        ci;
    logic [31:0]       rmerge;

`ifdef MEM_CTRL_FAIR_EN
    // last_q = 1 means the previous grant went to MEM
    logic last_q, last_d;
`endif

    // Arbitration: MEM has priority unless fairness hands a contended slot to IF
    always_comb begin
`ifdef MEM_CTRL_FAIR_EN
        grant_mem = mem_req_i & ~(if_req_i & last_q);
`else
        grant_mem = mem_req_i;
`endif
        grant_if  = if_req_i & ~grant_mem;
    end

    // Next-state logic for the transfer FSM and all registered outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        own_mem_d   = own_mem_q;
        rbuf_d      = rbuf_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        ram_addr_d  = ram_addr_q;
        ram_wr_d    = 1'b0;
        ram_dout_d  = ram_dout_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
`ifdef MEM_CTRL_FAIR_EN
        last_d      = last_q;
`endif
        nxt         = cnt_q + 3'd1;
        ci          = cnt_q[1:0] - 2'd1;
        rmerge      = rbuf_q;

        case (state_q)
            S_IDLE: begin
                if (grant_mem || grant_if) begin
                    addr_d     = grant_mem ? mem_addr_i[RAM_AW-1:0] : if_addr_i[RAM_AW-1:0];
                    n_d        = (grant_mem && mem_len_i == 2'b00) ? 3'd1 :
                                 (grant_mem && mem_len_i == 2'b01) ? 3'd2 : 3'd4;
                    we_d       = grant_mem & mem_we_i;
                    wdata_d    = mem_wdata_i;
                    own_mem_d  = grant_mem;
                    cnt_d      = 3'd0;
                    rbuf_d     = 32'd0;
                    ram_addr_d = addr_d;
                    ram_wr_d   = grant_mem & mem_we_i;
                    ram_dout_d = mem_wdata_i[7:0];
                    state_d    = S_XFER;
`ifdef MEM_CTRL_FAIR_EN
                    last_d     = grant_mem;
`endif
                end
            end
            S_XFER: begin
                cnt_d = nxt;
                if (we_q) begin
                    if (nxt == n_q) begin
                        state_d    = S_DONE;
                        if_done_d  = ~own_mem_q;
                        mem_done_d = own_mem_q;
                    end else begin
                        ram_addr_d = addr_q + RAM_AW'(nxt);
                        ram_wr_d   = 1'b1;
                        ram_dout_d = wdata_q[{nxt[1:0], 3'b000} +: 8];
                    end
                end else begin
                    // RAM answers one cycle late, so byte cnt-1 is on ram_din_i now
                    if (cnt_q != 3'd0) begin
                        rmerge[{ci, 3'b000} +: 8] = ram_din_i;
                    end
                    rbuf_d = rmerge;
                    if (nxt < n_q) begin
                        ram_addr_d = addr_q + RAM_AW'(nxt);
                    end
                    if (cnt_q == n_q) begin
                        state_d    = S_DONE;
                        if_done_d  = ~own_mem_q;
                        mem_done_d = own_mem_q;
                        if (own_mem_q) begin
                            mem_rdata_d = rmerge;
                        end else begin
                            if_data_d = rmerge;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; async reset aborts any transfer without a done pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            n_q         <= 3'd0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= 32'd0;
            own_mem_q   <= 1'b0;
            rbuf_q      <= 32'd0;
            if_data_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
            ram_addr_q  <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= 8'd0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
`ifdef MEM_CTRL_FAIR_EN
            last_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            own_mem_q   <= own_mem_d;
            rbuf_q      <= rbuf_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            ram_addr_q  <= ram_addr_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
`ifdef MEM_CTRL_FAIR_EN
            last_q      <= last_d;
`endif
        end
    end

    assign if_done_o   = if_done_q;
    assign if_data_o   = if_data_q;
    assign mem_done_o  = mem_done_q;
    assign mem_rdata_o = mem_rdata_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wr_o    = ram_wr_q;
    assign ram_dout_o  = ram_dout_q;
    assign stall_req_o = (if_req_i & ~if_done_q) | (mem_req_i & ~mem_done_q);

endmodule
